morse_unit_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 18 +
 rtl/morse_unit_timer_if.sv | 31 +++
 rtl/tick_prescaler.sv | 36 +++
 rtl/morse_unit_timer.sv | 108 ++++++++++
 tb/tb_morse_unit_timer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the Morse unit timer slice.
// Mode/state encodings and standard Morse unit counts.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS   = 7;

endpackage

// File: rtl/morse_unit_timer_if.sv
// Control/status bundle between a Morse encoder/decoder
// and the unit timer.
interface morse_unit_timer_if #(
  parameter int WID   = 5,
  parameter int CNT_W = 4
);

  logic             en;
  logic             start;
  logic             abort;
  logic             mode;
  logic [WID-1:0]   div;
  logic [CNT_W-1:0] units;

  logic [WID-1:0]   phase;
  logic [CNT_W-1:0] unit_cnt;
  logic             tick;
  logic             done;
  logic             busy;

  modport master (
    output en, start, abort, mode, div, units,
    input  phase, unit_cnt, tick, done, busy
  );

  modport slave (
    input  en, start, abort, mode, div, units,
    output phase, unit_cnt, tick, done, busy
  );

endinterface

// File: rtl/tick_prescaler.sv
// Programmable clock prescaler: one registered tick
// every div_q enabled cycles.
module tick_prescaler #(
  parameter int WID = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic [WID-1:0] div_q,
  output logic [WID-1:0] phase,
  output logic           tick
);

  logic last;

  assign last = (phase == div_q - WID'(1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (last) begin
        phase <= '0;
        tick  <= 1'b1;
      end else begin
        phase <= phase + WID'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_unit_timer.sv
// Morse unit timer: prescaled unit ticks counted into
// one-shot or periodic intervals with a done pulse.
module morse_unit_timer
  import timer_pkg::*;
#(
  parameter int WID   = 5,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  morse_unit_timer_if.slave bus
);

  state_t           st_q, st_n;
  logic [WID-1:0]   div_q, div_n;
  logic [CNT_W-1:0] units_q, units_n;
  logic             mode_q, mode_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             done_q, done_n;
  logic             busy_q;
  logic             clr;
  logic             pen;
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;

  tick_prescaler #(.WID(WID)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (pen),
    .div_q (div_q),
    .phase (bus.phase),
    .tick  (bus.tick)
  );

  // Mirrors the prescaler's wrap so the unit count
  // and done land on the same edge as tick.
  assign wrap    = (bus.phase == div_q - WID'(1));
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      div_q   <= WID'(1);
      units_q <= CNT_W'(1);
      mode_q  <= MODE_ONESHOT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_n;
      div_q   <= div_n;
      units_q <= units_n;
      mode_q  <= mode_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      busy_q  <= (st_n == ST_RUN);
    end
  end

  always_comb begin
    st_n    = st_q;
    div_n   = div_q;
    units_n = units_q;
    mode_n  = mode_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    clr     = 1'b0;
    pen     = 1'b0;
    if (bus.abort) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
      clr   = 1'b1;
    end else if (bus.start) begin
      st_n    = ST_RUN;
      div_n   = (bus.div == '0) ? WID'(1) : bus.div;
      units_n = (bus.units == '0) ? CNT_W'(1)
                                  : bus.units;
      mode_n  = bus.mode;
      cnt_n   = '0;
      clr     = 1'b1;
    end else if (st_q == ST_RUN) begin
      if (bus.en) begin
        pen = 1'b1;
        if (wrap) begin
          if (cnt_inc == units_q) begin
            done_n = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              cnt_n = '0;
            end else begin
              cnt_n = units_q;
              st_n  = ST_IDLE;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
    end else begin
      cnt_n = '0;
    end
  end

  assign bus.unit_cnt = cnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_morse_unit_timer.sv
// Directed bench for morse_unit_timer.
// Expected values are hand-derived per scenario.
module tb_morse_unit_timer;
  import timer_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  morse_unit_timer_if #(.WID(5), .CNT_W(4)) bus ();

  morse_unit_timer #(.WID(5), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int d, input int u,
                    input logic m);
    bus.div   = 5'(d);
    bus.units = 4'(u);
    bus.mode  = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int npulse;
    int e;
    int dedge;
    int ntick;
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = MODE_ONESHOT;
    bus.div   = '0;
    bus.units = '0;
    step();
    step();
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_cnt", int'(bus.unit_cnt), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    step();

    // one-shot 5 x 3
    bus.en = 1'b1;
    go(5, DASH_UNITS, MODE_ONESHOT);
    chk("os_busy0", int'(bus.busy), 1);
    chk("os_tick0", int'(bus.tick), 0);
    chk("os_phase0", int'(bus.phase), 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("os_tick", int'(bus.tick),
          (k % 5 == 0) ? 1 : 0);
      chk("os_done", int'(bus.done),
          (k == 15) ? 1 : 0);
      chk("os_cnt", int'(bus.unit_cnt), k / 5);
      chk("os_busy", int'(bus.busy),
          (k < 15) ? 1 : 0);
      chk("os_phase", int'(bus.phase), k % 5);
    end
    step();
    chk("os_cnt_end", int'(bus.unit_cnt), 0);
    chk("os_done_end", int'(bus.done), 0);
    chk("os_busy_end", int'(bus.busy), 0);

    // periodic 5 x 1, abort at 42
    go(5, DOT_UNITS, MODE_PERIODIC);
    npulse = 0;
    for (int k = 1; k <= 41; k++) begin
      if (k == 41) bus.abort = 1'b0;
      step();
      chk("per_tick", int'(bus.tick),
          (k % 5 == 0) ? 1 : 0);
      chk("per_done", int'(bus.done),
          (k % 5 == 0) ? 1 : 0);
      chk("per_busy", int'(bus.busy), 1);
      if (bus.done) npulse++;
    end
    chk("per_pulses", npulse, 8);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_phase", int'(bus.phase), 0);
    chk("abort_cnt", int'(bus.unit_cnt), 0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.tick || bus.done) npulse++;
    end
    chk("abort_quiet", npulse, 0);

    // pause for edges 7..13
    go(5, 3, MODE_ONESHOT);
    e     = 0;
    dedge = -1;
    for (int k = 1; k <= 25; k++) begin
      bus.en = (k >= 7 && k <= 13) ? 1'b0 : 1'b1;
      if (bus.en) e++;
      step();
      if (k >= 7 && k <= 13) begin
        chk("pz_phase", int'(bus.phase), 1);
        chk("pz_cnt", int'(bus.unit_cnt), 1);
        chk("pz_tick", int'(bus.tick), 0);
      end else begin
        chk("pz_tick", int'(bus.tick),
            (e % 5 == 0 && e <= 15) ? 1 : 0);
      end
      if (bus.done) dedge = k;
    end
    bus.en = 1'b1;
    chk("pz_done_edge", dedge, 22);

    // restart at edge 6
    go(4, 2, MODE_ONESHOT);
    for (int k = 1; k <= 14; k++) begin
      if (k == 6) begin
        bus.div   = 5'd2;
        bus.units = 4'd3;
        bus.start = 1'b1;
      end
      step();
      bus.start = 1'b0;
      chk("rs_tick", int'(bus.tick),
          (k == 4 || k == 8 || k == 10 || k == 12)
          ? 1 : 0);
      chk("rs_done", int'(bus.done),
          (k == 12) ? 1 : 0);
    end

    // zero div/units behave as 1/1
    go(0, 0, MODE_ONESHOT);
    step();
    chk("z_tick", int'(bus.tick), 1);
    chk("z_done", int'(bus.done), 1);
    chk("z_cnt", int'(bus.unit_cnt), 1);
    chk("z_busy", int'(bus.busy), 0);
    chk("z_phase", int'(bus.phase), 0);
    step();
    chk("z_cnt_end", int'(bus.unit_cnt), 0);
    chk("z_done_end", int'(bus.done), 0);

    // max ratio, div changed mid-run
    go(31, 15, MODE_ONESHOT);
    dedge = -1;
    ntick = 0;
    for (int k = 1; k <= 600 && dedge < 0; k++) begin
      if (k == 100) bus.div = 5'd3;
      if (k == 101) bus.units = 4'd2;
      step();
      if (bus.tick) ntick++;
      if (bus.done) dedge = k;
    end
    chk("max_done_edge", dedge, 465);
    chk("max_ticks", ntick, 15);

    // reset mid-run
    go(5, 3, MODE_ONESHOT);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_phase", int'(bus.phase), 0);
    chk("mr_cnt", int'(bus.unit_cnt), 0);
    chk("mr_tick", int'(bus.tick), 0);
    chk("mr_done", int'(bus.done), 0);
    chk("mr_busy", int'(bus.busy), 0);
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.tick || bus.done || bus.busy)
        npulse++;
    end
    chk("mr_quiet", npulse, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
